// File: rtl/mem_arb_pkg.sv
// Shared state encoding and slave load/store type codes for mem_port_arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } arb_state_e;

   localparam logic [2:0] LB  = 3'b001;
   localparam logic [2:0] LBU = 3'b010;
   localparam logic [2:0] LH  = 3'b011;
   localparam logic [2:0] LHU = 3'b100;
   localparam logic [2:0] LW  = 3'b111;

   localparam logic [2:0] SB  = 3'b001;
   localparam logic [2:0] SH  = 3'b010;
   localparam logic [2:0] SW  = 3'b011;

   function automatic logic [2:0] pick3(input logic [5:0] codes, input logic sel);
      pick3 = sel ? codes[5:3] : codes[2:0];
   endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-requester winner selection. MEM_ARB_RR_EN selects round-robin with a
// "last granted" pointer; otherwise requester 0 has fixed priority.
module rr_arbiter_2 (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [1:0] req_i,
   input  logic       advance_i,
   output logic       valid_o,
   output logic       winner_o
);

   assign valid_o = req_i[0] | req_i[1];

`ifdef MEM_ARB_RR_EN
   logic last_q;

   // Contended requests go to whoever was not granted last.
   always_comb begin
      winner_o = 1'b0;
      if (req_i == 2'b11) begin
         winner_o = ~last_q;
      end else begin
         winner_o = req_i[1];
      end
   end

   // Reset value 1 makes requester 0 the first contended winner.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         last_q <= 1'b1;
      end else if (advance_i && valid_o) begin
         last_q <= winner_o;
      end else begin
         last_q <= last_q;
      end
   end
`else
   logic unused_ok;

   assign unused_ok = clk_i ^ rst_i ^ advance_i;

   // Requester 0 always wins.
   always_comb begin
      winner_o = 1'b0;
      if (req_i[0]) begin
         winner_o = 1'b0;
      end else begin
         winner_o = req_i[1];
      end
   end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter in front of one synchronous memory slave: IDLE/ACCESS/RESP,
// one access per two cycles. Define MEM_ARB_RR_EN for round-robin contention.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 32
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic [1:0]          req,
   input  logic [1:0]          we,
   input  logic [2*ADDR_W-1:0] addr,
   input  logic [2*DATA_W-1:0] wd,
   input  logic [5:0]          load_choice,
   input  logic [5:0]          sw_choice,
   output logic [1:0]          gnt,
   output logic [1:0]          done,
   output logic [DATA_W-1:0]   rdata,
   output logic [ADDR_W-1:0]   s_A,
   output logic [DATA_W-1:0]   s_WD,
   output logic                s_WE,
   output logic [2:0]          s_load_choice,
   output logic [2:0]          s_sw_choice,
   input  logic [DATA_W-1:0]   s_RD
);

   arb_state_e          state_q;
   logic                idx_q;
   logic                we_q;
   logic                rd_q;
   logic [1:0]          gnt_q;
   logic [1:0]          done_q;
   logic [ADDR_W-1:0]   s_a_q;
   logic [DATA_W-1:0]   s_wd_q;
   logic                s_we_q;
   logic [2:0]          s_ld_q;
   logic [2:0]          s_sw_q;

   logic                win_valid;
   logic                win;
   logic                arb_fire;
   logic                we_d;
   logic [ADDR_W-1:0]   addr_d;
   logic [DATA_W-1:0]   wd_d;
   logic [2:0]          ld_d;
   logic [2:0]          sw_d;

   assign arb_fire = win_valid && ((state_q == IDLE) || (state_q == RESP));

   rr_arbiter_2 u_arb (
      .clk_i     (CLK),
      .rst_i     (RST),
      .req_i     (req),
      .advance_i (arb_fire),
      .valid_o   (win_valid),
      .winner_o  (win)
   );

   assign we_d   = win ? we[1] : we[0];
   assign addr_d = win ? addr[2*ADDR_W-1:ADDR_W] : addr[ADDR_W-1:0];
   assign wd_d   = win ? wd[2*DATA_W-1:DATA_W] : wd[DATA_W-1:0];
   assign ld_d   = pick3(load_choice, win);
   assign sw_d   = pick3(sw_choice, win);

   // Arbitration FSM; every slave/handshake output is loaded on the edge
   // that enters the state in which it must be visible.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= IDLE;
         idx_q   <= 1'b0;
         we_q    <= 1'b0;
         rd_q    <= 1'b0;
         gnt_q   <= 2'b00;
         done_q  <= 2'b00;
         s_a_q   <= {ADDR_W{1'b0}};
         s_wd_q  <= {DATA_W{1'b0}};
         s_we_q  <= 1'b0;
         s_ld_q  <= 3'b000;
         s_sw_q  <= 3'b000;
      end else begin
         gnt_q  <= 2'b00;
         done_q <= 2'b00;
         rd_q   <= 1'b0;
         s_a_q  <= {ADDR_W{1'b0}};
         s_wd_q <= {DATA_W{1'b0}};
         s_we_q <= 1'b0;
         s_ld_q <= 3'b000;
         s_sw_q <= 3'b000;
         case (state_q)
            IDLE, RESP: begin
               if (arb_fire) begin
                  state_q    <= ACCESS;
                  idx_q      <= win;
                  we_q       <= we_d;
                  gnt_q[win] <= 1'b1;
                  s_a_q      <= addr_d;
                  s_wd_q     <= wd_d;
                  s_we_q     <= we_d;
                  s_sw_q     <= sw_d;
                  s_ld_q     <= we_d ? 3'b000 : ld_d;
               end else begin
                  state_q <= IDLE;
               end
            end
            ACCESS: begin
               state_q       <= RESP;
               done_q[idx_q] <= 1'b1;
               rd_q          <= ~we_q;
               s_ld_q        <= s_ld_q;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // Slave read data is only valid during RESP, so it is gated, not re-registered.
   assign rdata         = rd_q ? s_RD : {DATA_W{1'b0}};
   assign gnt           = gnt_q;
   assign done          = done_q;
   assign s_A           = s_a_q;
   assign s_WD          = s_wd_q;
   assign s_WE          = s_we_q;
   assign s_load_choice = s_ld_q;
   assign s_sw_choice   = s_sw_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a behavioural
// synchronous memory slave that applies load/store type codes.
module tb_mem_port_arbiter;
   import mem_arb_pkg::*;

   localparam int AW = 12;
   localparam int DW = 32;

   logic          CLK = 1'b0;
   logic          RST;
   logic [1:0]    req;
   logic [1:0]    we;
   logic [2*AW-1:0] addr;
   logic [2*DW-1:0] wd;
   logic [5:0]    load_choice;
   logic [5:0]    sw_choice;
   logic [1:0]    gnt;
   logic [1:0]    done;
   logic [DW-1:0] rdata;
   logic [AW-1:0] s_A;
   logic [DW-1:0] s_WD;
   logic          s_WE;
   logic [2:0]    s_load_choice;
   logic [2:0]    s_sw_choice;
   logic [DW-1:0] s_RD;

   int total = 0;
   int bad   = 0;

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .CLK(CLK), .RST(RST), .req(req), .we(we), .addr(addr), .wd(wd),
      .load_choice(load_choice), .sw_choice(sw_choice),
      .gnt(gnt), .done(done), .rdata(rdata),
      .s_A(s_A), .s_WD(s_WD), .s_WE(s_WE),
      .s_load_choice(s_load_choice), .s_sw_choice(s_sw_choice), .s_RD(s_RD)
   );

   always #5 CLK = ~CLK;

   logic [DW-1:0] mem [0:(1<<AW)-1];

   always @(posedge CLK) begin
      if (s_WE) begin
         case (s_sw_choice)
            SB:      mem[s_A][7:0]  <= s_WD[7:0];
            SH:      mem[s_A][15:0] <= s_WD[15:0];
            default: mem[s_A]       <= s_WD;
         endcase
      end
      case (s_load_choice)
         LB:      s_RD <= {{24{mem[s_A][7]}}, mem[s_A][7:0]};
         LBU:     s_RD <= {24'h000000, mem[s_A][7:0]};
         LH:      s_RD <= {{16{mem[s_A][15]}}, mem[s_A][15:0]};
         LHU:     s_RD <= {16'h0000, mem[s_A][15:0]};
         default: s_RD <= mem[s_A];
      endcase
   end

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   task automatic set_cmd(input int i, input logic w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [2:0] ld, input logic [2:0] sc);
      we[i]              = w;
      addr[i*AW +: AW]   = a;
      wd[i*DW +: DW]     = d;
      load_choice[i*3 +: 3] = ld;
      sw_choice[i*3 +: 3]   = sc;
   endtask

   task automatic test_reset;
      RST = 1'b1; req = 2'b00; we = 2'b00; addr = '0; wd = '0;
      load_choice = 6'd0; sw_choice = 6'd0;
      tick; tick;
      total++; if (gnt !== 2'b00) begin bad++; $display("FAIL reset_gnt got %b exp 00", gnt); end
      total++; if (done !== 2'b00) begin bad++; $display("FAIL reset_done got %b exp 00", done); end
      total++; if (rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got %h exp 0", rdata); end
      total++;
      if ({s_WE, s_A, s_WD, s_load_choice, s_sw_choice} !== 51'd0) begin
         bad++; $display("FAIL reset_slave got we=%b a=%h wd=%h ld=%b sw=%b exp all 0",
                         s_WE, s_A, s_WD, s_load_choice, s_sw_choice);
      end
      RST = 1'b0;
      tick;
   endtask

   task automatic test_single_write;
      set_cmd(0, 1'b1, 12'h010, 32'hDEADBEEF, 3'b000, SW);
      req = 2'b01;
      tick;
      total++; if (gnt !== 2'b01) begin bad++; $display("FAIL wr_gnt got %b exp 01", gnt); end
      total++; if (s_WE !== 1'b1) begin bad++; $display("FAIL wr_swe got %b exp 1", s_WE); end
      total++; if (s_A !== 12'h010) begin bad++; $display("FAIL wr_sa got %h exp 010", s_A); end
      total++; if (s_WD !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_swd got %h exp deadbeef", s_WD); end
      total++; if (s_sw_choice !== 3'b011) begin bad++; $display("FAIL wr_ssw got %b exp 011", s_sw_choice); end
      total++; if (s_load_choice !== 3'b000) begin bad++; $display("FAIL wr_sld got %b exp 000", s_load_choice); end
      total++; if (done !== 2'b00) begin bad++; $display("FAIL wr_done_early got %b exp 00", done); end
      req = 2'b00;
      tick;
      total++; if (done !== 2'b01) begin bad++; $display("FAIL wr_done got %b exp 01", done); end
      total++; if (gnt !== 2'b00) begin bad++; $display("FAIL wr_gnt_resp got %b exp 00", gnt); end
      total++; if (rdata !== 32'h0) begin bad++; $display("FAIL wr_rdata got %h exp 0", rdata); end
      total++; if (s_WE !== 1'b0) begin bad++; $display("FAIL wr_swe_resp got %b exp 0", s_WE); end
      tick;
      total++; if (done !== 2'b00) begin bad++; $display("FAIL wr_done_idle got %b exp 00", done); end
   endtask

   task automatic test_read_back;
      set_cmd(1, 1'b0, 12'h010, 32'h0, LW, 3'b000);
      req = 2'b10;
      tick;
      total++; if (gnt !== 2'b10) begin bad++; $display("FAIL rd_gnt got %b exp 10", gnt); end
      total++; if (s_WE !== 1'b0) begin bad++; $display("FAIL rd_swe got %b exp 0", s_WE); end
      total++; if (s_load_choice !== 3'b111) begin bad++; $display("FAIL rd_sld got %b exp 111", s_load_choice); end
      req = 2'b00;
      tick;
      total++; if (done !== 2'b10) begin bad++; $display("FAIL rd_done got %b exp 10", done); end
      total++; if (rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_rdata got %h exp deadbeef", rdata); end
      total++; if (s_load_choice !== 3'b111) begin bad++; $display("FAIL rd_sld_resp got %b exp 111", s_load_choice); end
      tick;
      total++; if (rdata !== 32'h0) begin bad++; $display("FAIL rd_rdata_idle got %h exp 0", rdata); end

      set_cmd(0, 1'b1, 12'h011, 32'hABCD0080, 3'b000, SW);
      req = 2'b01;
      tick; req = 2'b00; tick; tick;
      set_cmd(1, 1'b0, 12'h011, 32'h0, LB, 3'b000);
      req = 2'b10;
      tick; req = 2'b00; tick;
      total++; if (done !== 2'b10) begin bad++; $display("FAIL lb_done got %b exp 10", done); end
      total++; if (rdata !== 32'hFFFFFF80) begin bad++; $display("FAIL lb_rdata got %h exp ffffff80", rdata); end
      tick;
      set_cmd(1, 1'b0, 12'h011, 32'h0, LBU, 3'b000);
      req = 2'b10;
      tick; req = 2'b00; tick;
      total++; if (rdata !== 32'h00000080) begin bad++; $display("FAIL lbu_rdata got %h exp 00000080", rdata); end
      tick;
   endtask

   task automatic test_contention;
      logic [1:0] exp;
      set_cmd(0, 1'b0, 12'h020, 32'h0, LW, 3'b000);
      set_cmd(1, 1'b0, 12'h030, 32'h0, LW, 3'b000);
      req = 2'b11;
      for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_RR_EN
         exp = (i % 2 == 1) ? 2'b10 : 2'b01;
`else
         exp = 2'b01;
`endif
         tick;
         total++; if (gnt !== exp) begin bad++; $display("FAIL cont_gnt%0d got %b exp %b", i, gnt, exp); end
         if (i == 3) req = 2'b00;
         tick;
         total++; if (done !== exp) begin bad++; $display("FAIL cont_done%0d got %b exp %b", i, done, exp); end
      end
      tick;
   endtask

   task automatic test_back_to_back;
      set_cmd(0, 1'b1, 12'h100, 32'h10000000, 3'b000, SW);
      req = 2'b01;
      for (int k = 0; k < 4; k++) begin
         tick;
         total++; if (gnt !== 2'b01) begin bad++; $display("FAIL b2b_gnt%0d got %b exp 01", k, gnt); end
         total++; if (s_A !== 12'h100 + 12'(k)) begin bad++; $display("FAIL b2b_sa%0d got %h exp %h", k, s_A, 12'h100 + 12'(k)); end
         total++; if (done !== 2'b00) begin bad++; $display("FAIL b2b_nodone%0d got %b exp 00", k, done); end
         if (k == 3) req = 2'b00;
         else set_cmd(0, 1'b1, 12'h100 + 12'(k + 1), 32'h10000000 + 32'(k + 1), 3'b000, SW);
         tick;
         total++; if (done !== 2'b01) begin bad++; $display("FAIL b2b_done%0d got %b exp 01", k, done); end
         total++; if (gnt !== 2'b00) begin bad++; $display("FAIL b2b_nognt%0d got %b exp 00", k, gnt); end
      end
      tick;
      set_cmd(1, 1'b0, 12'h102, 32'h0, LW, 3'b000);
      req = 2'b10;
      tick; req = 2'b00; tick;
      total++; if (rdata !== 32'h10000002) begin bad++; $display("FAIL b2b_readback got %h exp 10000002", rdata); end
      tick;
   endtask

   task automatic test_reset_mid_access;
      set_cmd(0, 1'b1, 12'h200, 32'h00000055, 3'b000, SW);
      req = 2'b01;
      tick;
      total++; if (gnt !== 2'b01) begin bad++; $display("FAIL rst_gnt_pre got %b exp 01", gnt); end
      req = 2'b00;
      RST = 1'b1;
      #1;
      total++; if (gnt !== 2'b00) begin bad++; $display("FAIL rst_gnt_async got %b exp 00", gnt); end
      total++; if (s_WE !== 1'b0) begin bad++; $display("FAIL rst_swe_async got %b exp 0", s_WE); end
      total++; if (s_A !== 12'h000) begin bad++; $display("FAIL rst_sa_async got %h exp 000", s_A); end
      tick; tick;
      RST = 1'b0;
      for (int c = 0; c < 3; c++) begin
         tick;
         total++; if (done !== 2'b00) begin bad++; $display("FAIL rst_nodone%0d got %b exp 00", c, done); end
      end
      set_cmd(0, 1'b0, 12'h010, 32'h0, LW, 3'b000);
      set_cmd(1, 1'b0, 12'h010, 32'h0, LW, 3'b000);
      req = 2'b11;
      tick;
      total++; if (gnt !== 2'b01) begin bad++; $display("FAIL rst_next_gnt got %b exp 01", gnt); end
      req = 2'b00;
      tick;
      total++; if (done !== 2'b01) begin bad++; $display("FAIL rst_next_done got %b exp 01", done); end
      tick;
   endtask

   initial begin
      test_reset;
      test_single_write;
      test_read_back;
      test_contention;
      test_back_to_back;
      test_reset_mid_access;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, the slave word-address width.
REQ-002 SHALL have parameter DATA_W, default 32, the data width.
REQ-003 SHALL have port CLK  in  1  the single clock; all state updates on rising edge.
REQ-004 SHALL have port RST  in  1  reset; asynchronous, active-high.
REQ-005 SHALL have port req  in  2  per-requester access request; bit i = requester i.
REQ-006 SHALL have port we  in  2  per-requester write enable.
REQ-007 SHALL have port addr  in  2*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W].
REQ-008 SHALL have port wd  in  2*DATA_W  packed write data.
REQ-009 SHALL have port load_choice  in  6  packed 3-bit load-type codes.
REQ-010 SHALL have port sw_choice  in  6  packed 3-bit store-type codes.
REQ-011 SHALL have port gnt  out  2  one-cycle accept pulse per requester.
REQ-012 SHALL have port done  out  2  one-cycle completion pulse per requester.
REQ-013 SHALL have port rdata  out  DATA_W  read data, valid while a done bit is high for a read.
REQ-014 SHALL have ports s_A (ADDR_W), s_WD (DATA_W), s_WE (1), s_load_choice (3) and s_sw_choice (3)  out, driving the shared memory slave.
REQ-015 SHALL have port s_RD  in  DATA_W  slave read data, valid one cycle after the slave samples the address.

Function
REQ-016 SHALL implement FSM states IDLE, ACCESS and RESP.
REQ-017 SHALL arbitrate in IDLE and RESP.
- Any req high: capture the winner's index, we, addr, wd and choices into a command register; next state ACCESS.
- Otherwise: next state IDLE.
REQ-018 SHALL go from ACCESS to RESP unconditionally.
REQ-019 SHALL assert gnt[winner] for exactly the ACCESS cycle; the requester SHALL hold its req and command stable until it sees gnt.
REQ-020 SHALL, in ACCESS, drive s_A, s_WD and s_sw_choice from the command register, and drive s_WE = command we.
REQ-021 SHALL drive s_load_choice from the command register during ACCESS and RESP for reads; it is 0 otherwise and 0 for writes.
REQ-022 SHALL, in RESP, assert done[winner] and drive rdata = s_RD for a read, or rdata = 0 for a write.
REQ-023 SHALL drive s_WE, s_A, s_WD, s_sw_choice, gnt, done and rdata to 0 outside the states named above.
REQ-024 SHALL give a latency of req seen in IDLE at cycle 0, gnt at cycle 1 and done at cycle 2; back-to-back service SHALL be one access per 2 cycles.
REQ-025 SHALL ignore a req that drops before arbitration; no access results.
REQ-026 SHALL forward choice codes unmodified; invalid codes are the slave's concern.
REQ-027 SHALL never issue a second command while one is in flight; only one of gnt and done is ever high per requester at a time.

Reset
REQ-028 SHALL, while RST is high, force the state to IDLE, all outputs to 0 and the round-robin pointer to "last = requester 1", so requester 0 wins first.
REQ-029 SHALL drop an in-flight access on reset mid-ACCESS or mid-RESP; no done pulse is produced after release.

Configuration
REQ-030 SHALL, with MEM_ARB_RR_EN defined, resolve simultaneous requests round-robin: grant the requester not most recently granted, with the pointer updated on each grant.
REQ-031 SHALL, without MEM_ARB_RR_EN, use fixed priority, with requester 0 always winning; the pointer logic is absent.

Structure
REQ-032 SHALL place in shared package mem_arb_pkg: the state enum, the load codes (LB=001, LBU=010, LH=011, LHU=100, LW=111) and the store codes (SB=001, SH=010, SW=011).
REQ-033 SHALL implement the winner selection and pointer in sub-module rr_arbiter_2.

Verification
REQ-034 SHALL cover a single write:
- Stimulus: req=01, we=01, addr0=0x010, wd0=0xDEADBEEF, sw0=011.
- Response: gnt=01 at cycle 1 with s_WE=1 and s_A=0x010; done=01 at cycle 2.
REQ-035 SHALL cover a read-back:
- Stimulus: req=10, addr1=0x010, load1=111.
- Response: done=10 at cycle 2 with rdata=0xDEADBEEF.
- Repeat with load1=001 and memory byte 0x80: rdata=0xFFFFFF80.
REQ-036 SHALL cover contention: req=11 held for 4 accesses.
- MEM_ARB_RR_EN defined: grant order 0,1,0,1.
- Undefined: grant order 0,0,0,0.
REQ-037 SHALL cover back-to-back traffic: req0 held high with a new command each gnt; done pulses every 2 cycles with no IDLE gap.
REQ-038 SHALL cover reset: RST asserted during ACCESS of a write; outputs go to 0 immediately, no done, and the next access after release goes to requester 0.
